// File: rtl/pipe_stall_if.sv
// pipe_stall_if
//   Bundles the event inputs, bank enables/clears and fill handshake of the
//   pipeline stall/flush sequencer.
//   Modports:
//     master : the sequencer (consumes events, drives enables/flushes/fill port)
//     slave  : the pipeline and fill engine side (drives events, consumes controls)
//   Optional feature macro: PIPE_PERF_CNT_EN adds the stall_cnt signal.
//   Parameters:
//     PERF_W : width of stall_cnt (only present with PIPE_PERF_CNT_EN)
interface pipe_stall_if #(
    parameter int PERF_W = 32
);
    // events from the pipeline / memory
    logic load_use;
    logic branch_taken;
    logic icache_miss;
    logic dcache_miss;
    logic halt;
    logic fill_done;
    // bank controls
    logic wen_pc;
    logic wen_ifid;
    logic wen_idex;
    logic wen_exmem;
    logic wen_memwb;
    logic flush_ifid;
    logic flush_idex;
    // fill port and status
    logic fill_req;
    logic fill_sel;
    logic fill_err;
    logic halted;
`ifdef PIPE_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cnt;
`endif

    modport master (
        input  load_use, branch_taken, icache_miss, dcache_miss, halt, fill_done,
        output wen_pc, wen_ifid, wen_idex, wen_exmem, wen_memwb,
        output flush_ifid, flush_idex,
        output fill_req, fill_sel, fill_err, halted
`ifdef PIPE_PERF_CNT_EN
        , output stall_cnt
`endif
    );

    modport slave (
        output load_use, branch_taken, icache_miss, dcache_miss, halt, fill_done,
        input  wen_pc, wen_ifid, wen_idex, wen_exmem, wen_memwb,
        input  flush_ifid, flush_idex,
        input  fill_req, fill_sel, fill_err, halted
`ifdef PIPE_PERF_CNT_EN
        , input stall_cnt
`endif
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl
//   Central stall/flush sequencer for a 5-stage pipeline. Drives the write
//   enables and synchronous clears of the PC and pipeline register banks,
//   resolves halt / D-miss / I-miss / taken-branch / load-use events and runs
//   the shared I/D cache fill handshake with a timeout.
//   Ports:
//     clk  : clock, all state updates on posedge
//     rst  : synchronous active-high reset
//     bus  : pipe_stall_if.master (events in, enables/flushes/fill port out)
//   Parameters:
//     FILL_TO : fill cycles allowed before timeout (timeout fires in the
//               FILL_TO-th cycle spent in a fill state)
//     TO_W    : width of the fill timeout counter
//     PERF_W  : width of stall_cnt
//   Optional feature macro: PIPE_PERF_CNT_EN enables the saturating stall
//   cycle counter (cycles with wen_pc==0).
//   Outputs are combinational from registered state plus current inputs, so
//   an event gates the enables of its own cycle.
module pipe_stall_ctrl #(
    parameter int FILL_TO = 255,
    parameter int TO_W    = 8,
    parameter int PERF_W  = 32
) (
    input  logic        clk,
    input  logic        rst,
    pipe_stall_if.master bus
);
    typedef enum logic [1:0] {RUN, IFILL, DFILL, HALT} state_t;

    // Counter value seen during the FILL_TO-th fill cycle (cleared on entry).
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(FILL_TO - 1);

    state_t          state_reg;
    logic [TO_W-1:0] to_cnt_reg;
    logic            fill_err_reg;

    logic wen_pc, wen_ifid, wen_idex, wen_exmem, wen_memwb;
    logic flush_ifid, flush_idex;
    logic fill_req, fill_sel, halted;

    // State, timeout counter and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= RUN;
            to_cnt_reg   <= '0;
            fill_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                RUN: begin
                    to_cnt_reg <= '0;
                    if (bus.halt)             state_reg <= HALT;
                    else if (bus.dcache_miss) state_reg <= DFILL;
                    else if (bus.icache_miss) state_reg <= IFILL;
                end
                IFILL, DFILL: begin
                    // fill_done beats a coincident timeout
                    if (bus.fill_done) begin
                        to_cnt_reg <= '0;
                        if (state_reg == DFILL && bus.icache_miss)
                            state_reg <= IFILL;
                        else
                            state_reg <= RUN;
                    end else if (to_cnt_reg == TO_LAST) begin
                        to_cnt_reg   <= '0;
                        fill_err_reg <= 1'b1;
                        state_reg    <= HALT;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    // HALT is left only through rst
                    to_cnt_reg <= '0;
                end
            endcase
        end
    end

    // Bank enables, clears and fill port
    always_comb begin
        wen_pc     = 1'b0;
        wen_ifid   = 1'b0;
        wen_idex   = 1'b0;
        wen_exmem  = 1'b0;
        wen_memwb  = 1'b0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        fill_req   = 1'b0;
        fill_sel   = 1'b0;
        halted     = 1'b0;
        if (!rst) begin
            case (state_reg)
                RUN: begin
                    if (bus.halt || bus.dcache_miss || bus.icache_miss) begin
                        // full freeze, everything stays at 0
                    end else if (bus.branch_taken) begin
                        // squash the two younger instructions; any load_use
                        // belongs to a squashed instruction and is dropped
                        {wen_pc, wen_ifid, wen_idex, wen_exmem, wen_memwb} = 5'b11111;
                        flush_ifid = 1'b1;
                        flush_idex = 1'b1;
                    end else if (bus.load_use) begin
                        // hold PC and IF/ID, inject a bubble into ID/EX
                        wen_idex   = 1'b1;
                        wen_exmem  = 1'b1;
                        wen_memwb  = 1'b1;
                        flush_idex = 1'b1;
                    end else begin
                        {wen_pc, wen_ifid, wen_idex, wen_exmem, wen_memwb} = 5'b11111;
                    end
                end
                IFILL: fill_req = 1'b1;
                DFILL: begin
                    fill_req = 1'b1;
                    fill_sel = 1'b1;
                end
                default: halted = 1'b1;
            endcase
        end
    end

    assign bus.wen_pc     = wen_pc;
    assign bus.wen_ifid   = wen_ifid;
    assign bus.wen_idex   = wen_idex;
    assign bus.wen_exmem  = wen_exmem;
    assign bus.wen_memwb  = wen_memwb;
    assign bus.flush_ifid = flush_ifid;
    assign bus.flush_idex = flush_idex;
    assign bus.fill_req   = fill_req;
    assign bus.fill_sel   = fill_sel;
    assign bus.fill_err   = fill_err_reg;
    assign bus.halted     = halted;

`ifdef PIPE_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cnt_reg;

    // Saturating count of cycles where the PC is held
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt_reg <= '0;
        else if (!wen_pc && (stall_cnt_reg != '1))
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end

    assign bus.stall_cnt = stall_cnt_reg;
`endif
endmodule
